// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the code lock controller.
package code_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MATCH   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int unsigned TRIES_W       = 3;
  localparam int unsigned LED_HOLD_DEF  = 8;
  localparam int unsigned LOCKOUT_DEF   = 16;

  // The counter is loaded with N-1, so ceil(log2(N)) bits suffice; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned v;
    int unsigned r;
    v = (a > b) ? a : b;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned CNT_W = cnt_width(LED_HOLD_DEF, LOCKOUT_DEF);

endpackage

// File: rtl/code_lock_ctrl_btn_edge_det.sv
// Rising-edge press detector for a level button; history resets high so a
// button held through reset does not register as a press.
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b1;
    else        r_q <= i_btn;
  end

  assign o_press = i_btn & ~r_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock sequencer: store a code, check guesses, timed LED and lockout.
// Optional macro CODE_LOCK_CLEAR_EN: simultaneous presses in IDLE/ARMED clear the code.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned MAX_TRIES       = 3,
  parameter int unsigned LED_HOLD_CYCLES = LED_HOLD_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   no,
  input  logic               push1,
  input  logic               push2,
  output logic               ledpin,
  output logic               locked_out,
  output logic [TRIES_W-1:0] tries_left,
  output logic               code_valid
);

  localparam int unsigned         CW         = cnt_width(LED_HOLD_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TRIES_W-1:0]  TRIES_INIT = TRIES_W'(MAX_TRIES);
  localparam logic [CW-1:0]       LED_LOAD   = CW'(LED_HOLD_CYCLES - 1);
  localparam logic [CW-1:0]       LOCK_LOAD  = CW'(LOCKOUT_CYCLES - 1);

  logic w_press1, w_press2;

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_code,  w_code_nxt;
  logic [CW-1:0]       r_cnt,   w_cnt_nxt;
  logic [TRIES_W-1:0]  r_tries, w_tries_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_led,   w_led_nxt;
  logic                r_lock,  w_lock_nxt;

  btn_edge_det u_edge1 (.clk(clk), .rst_n(rst_n), .i_btn(push1), .o_press(w_press1));
  btn_edge_det u_edge2 (.clk(clk), .rst_n(rst_n), .i_btn(push2), .o_press(w_press2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_cnt   <= '0;
      r_tries <= TRIES_INIT;
      r_valid <= 1'b0;
      r_led   <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tries <= w_tries_nxt;
      r_valid <= w_valid_nxt;
      r_led   <= w_led_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    w_valid_nxt = r_valid;
    w_led_nxt   = r_led;
    w_lock_nxt  = r_lock;
    case (r_state)
      // IDLE and ARMED share press1 handling; press2 only acts once a code is armed.
      IDLE, ARMED: begin
`ifdef CODE_LOCK_CLEAR_EN
        if (w_press1 && w_press2) begin
          w_code_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_tries_nxt = TRIES_INIT;
          w_state_nxt = IDLE;
        end else
`endif
        if (w_press1) begin
          w_code_nxt  = no;
          w_valid_nxt = 1'b1;
          w_tries_nxt = TRIES_INIT;
          w_state_nxt = ARMED;
        end else if (w_press2 && (r_state == ARMED)) begin
          if (no == r_code) begin
            w_led_nxt   = 1'b1;
            w_cnt_nxt   = LED_LOAD;
            w_tries_nxt = TRIES_INIT;
            w_state_nxt = MATCH;
          end else if (r_tries > 3'd1) begin
            w_tries_nxt = r_tries - 3'd1;
          end else begin
            w_tries_nxt = '0;
            w_lock_nxt  = 1'b1;
            w_cnt_nxt   = LOCK_LOAD;
            w_state_nxt = LOCKOUT;
          end
        end
      end
      MATCH: begin
        if (r_cnt == '0) begin
          w_led_nxt   = 1'b0;
          w_state_nxt = ARMED;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      LOCKOUT: begin
        if (r_cnt == '0) begin
          w_lock_nxt  = 1'b0;
          w_tries_nxt = TRIES_INIT;
          w_state_nxt = ARMED;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    ledpin     = r_led;
    locked_out = r_lock;
    tries_left = r_tries;
    code_valid = r_valid;
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: vector table, hand sequences and a
// randomized run against a counter-based behavioural model.
module tb_code_lock_ctrl;

  localparam int MAXT  = 3;
  localparam int LEDH  = 8;
  localparam int LOCKC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] no;
  logic       push1, push2;
  logic       ledpin, locked_out, code_valid;
  logic [2:0] tries_left;

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .WIDTH(4), .MAX_TRIES(MAXT), .LED_HOLD_CYCLES(LEDH), .LOCKOUT_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .no(no), .push1(push1), .push2(push2),
    .ledpin(ledpin), .locked_out(locked_out), .tries_left(tries_left), .code_valid(code_valid)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining-cycle counts instead of states.
  logic [3:0] m_code;
  bit         m_valid;
  int         m_tries, m_led_rem, m_lock_rem;
  bit         m_prev1, m_prev2;

  task automatic model_reset();
    m_code = '0; m_valid = 0; m_tries = MAXT;
    m_led_rem = 0; m_lock_rem = 0; m_prev1 = 1; m_prev2 = 1;
  endtask

  task automatic model_step();
    bit p1, p2;
    p1 = push1 & ~m_prev1;
    p2 = push2 & ~m_prev2;
    m_prev1 = push1;
    m_prev2 = push2;
    if (m_led_rem > 0) begin
      m_led_rem--;
    end else if (m_lock_rem > 0) begin
      m_lock_rem--;
      if (m_lock_rem == 0) m_tries = MAXT;
`ifdef CODE_LOCK_CLEAR_EN
    end else if (p1 && p2) begin
      m_code = '0; m_valid = 0; m_tries = MAXT;
`endif
    end else if (p1) begin
      m_code = no; m_valid = 1; m_tries = MAXT;
    end else if (p2 && m_valid) begin
      if (no == m_code) begin
        m_led_rem = LEDH; m_tries = MAXT;
      end else if (m_tries > 1) begin
        m_tries--;
      end else begin
        m_tries = 0; m_lock_rem = LOCKC;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " ledpin"},     32'(ledpin),     32'(m_led_rem > 0));
    chk({tag, " locked_out"}, 32'(locked_out), 32'(m_lock_rem > 0));
    chk({tag, " tries_left"}, 32'(tries_left), 32'(m_tries));
    chk({tag, " code_valid"}, 32'(code_valid), 32'(m_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    cmp_model("model");
  endtask

  typedef struct {
    bit         p1, p2;
    logic [3:0] code;
    bit         led, lock;
    logic [2:0] tries;
    bit         valid;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit p1, input bit p2, input logic [3:0] c, input bit led,
                     input bit lock, input logic [2:0] tr, input bit v, input int n);
    vec_t e;
    e.p1 = p1; e.p2 = p2; e.code = c; e.led = led; e.lock = lock; e.tries = tr; e.valid = v;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  initial begin
    logic [3:0] A, B;
    int led_hi, led_rise;
    bit led_prev;
    A = 4'b1010;
    B = 4'b1011;

    // Reset state
    rst_n = 1'b0; push1 = 1'b0; push2 = 1'b0; no = '0;
    model_reset();
    #12;
    chk("reset ledpin", 32'(ledpin), 0);
    chk("reset locked_out", 32'(locked_out), 0);
    chk("reset tries_left", 32'(tries_left), 3);
    chk("reset code_valid", 32'(code_valid), 0);
    rst_n = 1'b1;

    // Match pulse, three misses into lockout, ignored press during lockout, match after
    add(0,0,A, 0,0,3,0, 1);
    add(1,0,A, 0,0,3,1, 1);
    add(0,0,A, 0,0,3,1, 1);
    add(0,1,A, 1,0,3,1, 1);
    add(0,0,A, 1,0,3,1, 7);
    add(0,0,A, 0,0,3,1, 2);
    add(1,0,B, 0,0,3,1, 1);
    add(0,0,A, 0,0,3,1, 1);
    add(0,1,A, 0,0,2,1, 1);
    add(0,0,A, 0,0,2,1, 1);
    add(0,1,A, 0,0,1,1, 1);
    add(0,0,A, 0,0,1,1, 1);
    add(0,1,A, 0,1,0,1, 1);
    add(0,0,B, 0,1,0,1, 2);
    add(0,1,B, 0,1,0,1, 1);
    add(0,0,B, 0,1,0,1, 12);
    add(0,0,B, 0,0,3,1, 1);
    add(0,1,B, 1,0,3,1, 1);
    add(0,0,B, 1,0,3,1, 7);
    add(0,0,B, 0,0,3,1, 1);
    foreach (vecs[i]) begin
      push1 = vecs[i].p1; push2 = vecs[i].p2; no = vecs[i].code;
      tick();
      chk($sformatf("vec%0d ledpin", i),     32'(ledpin),     32'(vecs[i].led));
      chk($sformatf("vec%0d locked_out", i), 32'(locked_out), 32'(vecs[i].lock));
      chk($sformatf("vec%0d tries_left", i), 32'(tries_left), 32'(vecs[i].tries));
      chk($sformatf("vec%0d code_valid", i), 32'(code_valid), 32'(vecs[i].valid));
    end

    // Held push2: one pulse only
    push1 = 1; no = 4'b0011; tick();
    push1 = 0; tick();
    push2 = 1; led_hi = 0; led_rise = 0; led_prev = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ledpin) led_hi++;
      if (ledpin && !led_prev) led_rise++;
      led_prev = ledpin;
    end
    chk("held push2 led cycles", 32'(led_hi), 8);
    chk("held push2 led pulses", 32'(led_rise), 1);
    push2 = 0; tick();

    // Simultaneous presses
    push1 = 1; no = 4'b1111; tick();
    push1 = 0; tick();
    push1 = 1; push2 = 1; no = 4'b0101; tick();
`ifdef CODE_LOCK_CLEAR_EN
    chk("simul code_valid", 32'(code_valid), 0);
    chk("simul tries_left", 32'(tries_left), 3);
`else
    chk("simul code_valid", 32'(code_valid), 1);
`endif
    chk("simul ledpin", 32'(ledpin), 0);
    push1 = 0; push2 = 0; tick();
    push2 = 1; tick();
`ifdef CODE_LOCK_CLEAR_EN
    chk("after simul press2 led", 32'(ledpin), 0);
`else
    chk("after simul press2 led", 32'(ledpin), 1);
`endif
    push2 = 0;
    repeat (10) tick();

    // Reset mid-MATCH at LED cycle 3
    push1 = 1; no = 4'b1001; tick();
    push1 = 0; tick();
    push2 = 1; tick();
    push2 = 0; tick(); tick();
    chk("pre-reset ledpin", 32'(ledpin), 1);
    #2; rst_n = 0; model_reset(); #1;
    chk("async reset ledpin", 32'(ledpin), 0);
    chk("async reset code_valid", 32'(code_valid), 0);
    tick();
    rst_n = 1;
    push2 = 1; tick();
    push2 = 0; tick();
    push2 = 1; tick();
    chk("press2 after reset led", 32'(ledpin), 0);
    chk("press2 after reset valid", 32'(code_valid), 0);
    push2 = 0; tick();

    // push1 held through reset release
    push1 = 1; no = 4'b0110;
    #2; rst_n = 0; model_reset();
    tick(); tick();
    rst_n = 1;
    repeat (3) tick();
    chk("held push1 no store", 32'(code_valid), 0);
    push1 = 0; tick();
    push1 = 1; tick();
    chk("push1 re-press stores", 32'(code_valid), 1);
    push1 = 0; tick();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0; model_reset();
        tick();
        rst_n = 1;
      end
      no    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      push1 = ($urandom_range(0, 9) == 0);
      push2 = ($urandom_range(0, 2) == 0);
      tick();
      chk("exclusive led/lock", 32'(ledpin & locked_out), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
